pe_sequencer: RTL and testbench

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_sequencer_pkg.sv | 13 +
 rtl/pe_sequencer_if.sv | 15 +
 rtl/pe_sequencer_seq_counter.sv | 20 ++
 rtl/pe_sequencer.sv | 61 ++++++
 tb/tb_pe_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_sequencer_pkg.sv
// pe_sequencer_pkg: state/mode encodings and default job sizing shared by the PE controller and benches
package pe_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PROC, FIN} state_t;
  localparam logic [2:0] MOD_CONV = 3'b001;
  localparam logic [2:0] MOD_FC = 3'b010;
  localparam logic [2:0] MOD_POOL = 3'b100;
  localparam int DEF_PROC_LEN = 32;
  localparam int DEF_CONV_WCNT = 9;
  localparam int DEF_FC_WCNT = 16;
  function automatic logic is_onehot(input logic [2:0] m);
    return m inside {MOD_CONV, MOD_FC, MOD_POOL};
  endfunction
endpackage

// File: rtl/pe_sequencer_if.sv
// pe_sequencer_if: job request / weight load / PE control bundle between a host (master) and the sequencer (slave)
// host -> sequencer: mod, start, abort, weight_ready
// sequencer -> host: weight_in_valid, weight_addr, process_enable, busy, done, mode_err
interface pe_sequencer_if;
  import pe_sequencer_pkg::*;
  logic [2:0] mod;
  logic start, abort, weight_ready;
  logic weight_in_valid;
  logic [3:0] weight_addr;
  logic process_enable, busy, done, mode_err;
  modport master(output mod, start, abort, weight_ready,
                 input weight_in_valid, weight_addr, process_enable, busy, done, mode_err);
  modport slave(input mod, start, abort, weight_ready,
                output weight_in_valid, weight_addr, process_enable, busy, done, mode_err);
endinterface

// File: rtl/pe_sequencer_seq_counter.sv
// seq_counter: loadable, clearable, enabled up-counter with terminal-count flag
// clk, rst (async high); clr > load > en priority; last is the terminal value; tc = (q == last)
module seq_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc
);
  assign tc = q == last;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (load) q <= load_val;
    else if (en) q <= q + W'(1);
endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: IDLE/LOAD/PROC/FIN job sequencer loading weights then enabling the PE array
// clk, rst (async high); bus: pe_sequencer_if.slave carrying job request, weight handshake and status outputs
module pe_sequencer import pe_sequencer_pkg::*; #(
  parameter int PROC_LEN = DEF_PROC_LEN,
  parameter int CONV_WCNT = DEF_CONV_WCNT,
  parameter int FC_WCNT = DEF_FC_WCNT
) (
  input logic clk,
  input logic rst,
  pe_sequencer_if.slave bus
);
  localparam logic [7:0] PLAST = 8'(PROC_LEN - 1);
  state_t state, nxt;
  logic [2:0] mode_q;
  logic [3:0] wlast;
  logic [7:0] pcnt;
  logic wtc, ptc, xfer, go, bad;
  assign go = state == IDLE && bus.start && !bus.abort;
  assign bad = go && !is_onehot(bus.mod);
  assign xfer = state == LOAD && bus.weight_ready;
  assign wlast = mode_q == MOD_FC ? 4'(FC_WCNT - 1) : 4'(CONV_WCNT - 1);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = go && !bad ? (bus.mod == MOD_POOL ? PROC : LOAD) : IDLE;
      LOAD: nxt = bus.abort ? IDLE : xfer && wtc ? PROC : LOAD;
      PROC: nxt = bus.abort ? IDLE : ptc ? FIN : PROC;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // outputs are decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= '0;
      bus.weight_in_valid <= 1'b0;
      bus.process_enable <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.mode_err <= 1'b0;
    end else begin
      mode_q <= go && !bad ? bus.mod : mode_q;
      bus.weight_in_valid <= nxt == LOAD;
      bus.process_enable <= nxt == PROC;
      bus.busy <= nxt != IDLE;
      bus.done <= nxt == FIN;
      bus.mode_err <= bad;
    end
  // counters clear whenever the next state leaves their phase, covering abort and the final beat
  seq_counter #(.W(4)) u_waddr (
    .clk(clk), .rst(rst), .clr(nxt != LOAD), .load(1'b0), .en(xfer),
    .load_val(4'd0), .last(wlast), .q(bus.weight_addr), .tc(wtc)
  );
  seq_counter #(.W(8)) u_pcnt (
    .clk(clk), .rst(rst), .clr(nxt != PROC), .load(1'b0), .en(state == PROC),
    .load_val(8'd0), .last(PLAST), .q(pcnt), .tc(ptc)
  );
  assert property (@(posedge clk) disable iff (rst) state != PROC || pcnt <= PLAST);
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: randomized self-checking bench for pe_sequencer against a trace-level job model
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;
  localparam int PROC_LEN = 32;
  localparam int CONV_WCNT = 9;
  localparam int FC_WCNT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic rdy [512];
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  pe_sequencer_if bus();
  pe_sequencer #(.PROC_LEN(PROC_LEN), .CONV_WCNT(CONV_WCNT), .FC_WCNT(FC_WCNT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // observed vector: {busy, weight_in_valid, weight_addr[3:0], process_enable, done, mode_err}
  function automatic logic [8:0] outv();
    return {bus.busy, bus.weight_in_valid, bus.weight_addr, bus.process_enable, bus.done, bus.mode_err};
  endfunction
  // expected per-cycle outputs from the cycle after the start edge, from the job rules
  function automatic void build_exp(input logic [2:0] m, input int pad);
    int a, j, w;
    exp_q.delete();
    if (!(m inside {3'b001, 3'b010, 3'b100})) exp_q.push_back(9'b0_0_0000_0_0_1);
    else begin
      if (m != 3'b100) begin
        w = m == 3'b010 ? FC_WCNT : CONV_WCNT;
        a = 0;
        j = 0;
        while (a < w) begin
          exp_q.push_back({2'b11, 4'(a), 3'b000});
          if (rdy[j]) a++;
          j++;
        end
      end
      repeat (PROC_LEN) exp_q.push_back(9'b1_0_0000_1_0_0);
      exp_q.push_back(9'b1_0_0000_0_1_0);
    end
    repeat (pad) exp_q.push_back(9'b0);
  endfunction
  task automatic run_job(input logic [2:0] m, input int ncyc, input int busy_start_at);
    obs_q.delete();
    bus.mod = m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      obs_q.push_back(outv());
      bus.mod = 3'($urandom);
      bus.start = j == busy_start_at;
      bus.weight_ready = rdy[j];
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.weight_ready = 1'b0;
  endtask
  task automatic test_reset();
    bus.mod = MOD_CONV;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.weight_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (outv() !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, outv(), 9'b0);
      end
    end
    bus.start = 1'b0;
    bus.weight_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (outv() !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected %b", outv(), 9'b0);
    end
  endtask
  task automatic test_conv();
    int dcnt, didx;
    foreach (rdy[j]) rdy[j] = 1'b1;
    build_exp(MOD_CONV, 1);
    run_job(MOD_CONV, exp_q.size(), -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL conv_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    dcnt = 0;
    didx = -1;
    foreach (obs_q[i]) if (obs_q[i][1]) begin dcnt++; if (didx < 0) didx = i; end
    // job spans 1 + WCNT + PROC_LEN + 1 cycles counting the start cycle; index 0 is the second
    n_checks++;
    if (dcnt !== 1 || didx !== 1 + CONV_WCNT + PROC_LEN + 1 - 2) begin
      n_fail++;
      $display("FAIL conv_done_time: got count %0d index %0d expected count 1 index %0d", dcnt, didx, CONV_WCNT + PROC_LEN);
    end
  endtask
  task automatic test_fc_backpressure();
    int k;
    foreach (rdy[j]) rdy[j] = j[0];
    build_exp(MOD_FC, 1);
    run_job(MOD_FC, exp_q.size(), -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fc_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    k = 0;
    foreach (obs_q[i]) if (obs_q[i][7] && rdy[i]) begin
      n_checks++;
      if (obs_q[i][6:3] !== 4'(k)) begin
        n_fail++;
        $display("FAIL fc_beat_addr beat %0d: got %0d expected %0d", k, obs_q[i][6:3], k);
      end
      k++;
    end
    n_checks++;
    if (k !== FC_WCNT) begin
      n_fail++;
      $display("FAIL fc_beat_count: got %0d expected %0d", k, FC_WCNT);
    end
  endtask
  task automatic test_pool_and_invalid();
    logic [2:0] bad_modes [5] = '{3'b011, 3'b000, 3'b111, 3'b101, 3'b110};
    foreach (rdy[j]) rdy[j] = 1'b1;
    build_exp(MOD_POOL, 1);
    run_job(MOD_POOL, exp_q.size(), -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pool_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (bad_modes[b]) begin
      build_exp(bad_modes[b], 3);
      run_job(bad_modes[b], exp_q.size(), -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL bad_mode_%b cycle %0d: got %b expected %b", bad_modes[b], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_abort();
    int seen;
    bus.mod = MOD_CONV;
    bus.start = 1'b1;
    bus.weight_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (outv() !== {2'b11, 4'd5, 3'b000}) begin
      n_fail++;
      $display("FAIL abort_pre_addr: got %b expected %b", outv(), {2'b11, 4'd5, 3'b000});
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_checks++;
    if (outv() !== 9'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected %b", outv(), 9'b0);
    end
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (outv() !== 9'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.mod = MOD_POOL;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (outv() !== 9'b0) begin
        n_fail++;
        $display("FAIL abort_start_collision cycle %0d: got %b expected %b", i, outv(), 9'b0);
      end
      @(posedge clk); #1;
    end
    bus.weight_ready = 1'b0;
  endtask
  task automatic test_async_reset();
    foreach (rdy[j]) rdy[j] = 1'b1;
    bus.mod = MOD_CONV;
    bus.start = 1'b1;
    bus.weight_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (CONV_WCNT + 9) begin @(posedge clk); #1; end
    n_checks++;
    if (outv() !== 9'b1_0_0000_1_0_0) begin
      n_fail++;
      $display("FAIL async_pre_proc: got %b expected %b", outv(), 9'b1_0_0000_1_0_0);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (outv() !== 9'b0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b expected %b", outv(), 9'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.weight_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (outv() !== 9'b0) begin
      n_fail++;
      $display("FAIL async_wait_start: got %b expected %b", outv(), 9'b0);
    end
    build_exp(MOD_CONV, 1);
    run_job(MOD_CONV, exp_q.size(), -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL post_reset_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    int dcnt;
    foreach (rdy[j]) rdy[j] = 1'b1;
    build_exp(MOD_CONV, 0);
    for (int r = 0; r < 2; r++) begin
      run_job(MOD_CONV, exp_q.size(), r == 0 ? CONV_WCNT + 11 : -1);
      dcnt = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_trace run %0d cycle %0d: got %b expected %b", r, i, obs_q[i], exp_q[i]);
        end
        if (obs_q[i][1]) dcnt++;
      end
      n_checks++;
      if (dcnt !== 1) begin
        n_fail++;
        $display("FAIL b2b_done_count run %0d: got %0d expected 1", r, dcnt);
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_random_jobs();
    logic [2:0] m;
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0: m = MOD_CONV;
        1: m = MOD_FC;
        default: m = MOD_POOL;
      endcase
      foreach (rdy[j]) rdy[j] = j >= 64 || $urandom_range(0, 3) != 0;
      build_exp(m, 1);
      run_job(m, exp_q.size(), -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_job %0d mode %b cycle %0d: got %b expected %b", r, m, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  initial begin
    bus.mod = 3'b000;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.weight_ready = 1'b0;
    test_reset();
    test_conv();
    test_fc_backpressure();
    test_pool_and_invalid();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random_jobs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
